// File: rtl/pipelined_control_path.sv
// RV32I pipelined control path: ID decode, ID/EX, EX/MEM, MEM/WB control.
// Branch/jump resolution in EX self-flushes the wrong-path instruction.
module pipelined_control_path #(
  parameter int ALU_CTL_W          = 4,
  parameter int SUPPORT_SHIFTS     = 1,
  parameter int SUPPORT_EXT_BRANCH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_f3,
  input  logic                 i_f7_b5,
  input  logic                 i_flush_e,
  input  logic                 i_zero,
  input  logic                 i_lt,
  input  logic                 i_ltu,
  output logic [2:0]           o_imm_src_d,
  output logic                 o_illegal_d,
  output logic [ALU_CTL_W-1:0] o_alu_ctl_e,
  output logic                 o_alu_src_opa_e,
  output logic                 o_alu_src_opb_e,
  output logic [1:0]           o_pc_src_e,
  output logic                 o_flush_d,
  output logic                 o_load_e,
  output logic                 o_illegal_e,
  output logic                 o_mem_write_m,
  output logic                 o_reg_write_m,
  output logic [1:0]           o_result_src_m,
  output logic                 o_reg_write_w,
  output logic [1:0]           o_result_src_w
);

  typedef struct packed {
    logic [3:0] alu;
    logic       opa;
    logic       opb;
    logic       rw;
    logic       mw;
    logic [1:0] rs;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       load;
    logic       ill;
    logic [2:0] f3;
  } id_ex_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] rs;
  } ex_mem_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
  } mem_wb_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;

  localparam bit SH  = (SUPPORT_SHIFTS != 0);
  localparam bit EXT = (SUPPORT_EXT_BRANCH != 0);

  id_ex_t  dec;
  id_ex_t  ex_d, ex_q;
  ex_mem_t mem_d, mem_q;
  mem_wb_t wb_d, wb_q;
  logic [2:0] imm;
  logic       bad;
  logic       taken;

  always_comb begin
    dec = '0;
    imm = 3'b000;
    bad = 1'b0;
    unique case (i_opcode)
      OP_R: begin
        dec.rw = 1'b1;
        unique case (i_f3)
          3'b000: dec.alu = i_f7_b5 ? A_SUB : A_ADD;
          3'b001: begin dec.alu = A_SLL;  bad = !SH || i_f7_b5; end
          3'b010: begin dec.alu = A_SLT;  bad = i_f7_b5; end
          3'b011: begin dec.alu = A_SLTU; bad = i_f7_b5; end
          3'b100: begin dec.alu = A_XOR;  bad = i_f7_b5; end
          3'b101: begin
            dec.alu = i_f7_b5 ? A_SRA : A_SRL;
            bad     = !SH;
          end
          3'b110: begin dec.alu = A_OR;   bad = i_f7_b5; end
          default: begin dec.alu = A_AND; bad = i_f7_b5; end
        endcase
      end
      OP_I: begin
        dec.rw  = 1'b1;
        dec.opb = 1'b1;
        unique case (i_f3)
          3'b000: dec.alu = A_ADD;
          3'b001: begin dec.alu = A_SLL; bad = !SH; end
          3'b010: dec.alu = A_SLT;
          3'b011: dec.alu = A_SLTU;
          3'b100: dec.alu = A_XOR;
          3'b101: begin
            dec.alu = i_f7_b5 ? A_SRA : A_SRL;
            bad     = !SH;
          end
          3'b110: dec.alu = A_OR;
          default: dec.alu = A_AND;
        endcase
      end
      OP_L: begin
        dec.rw   = 1'b1;
        dec.opb  = 1'b1;
        dec.rs   = 2'b01;
        dec.load = 1'b1;
        bad      = (i_f3 != 3'b010);
      end
      OP_S: begin
        dec.mw  = 1'b1;
        dec.opb = 1'b1;
        imm     = 3'b001;
        bad     = (i_f3 != 3'b010);
      end
      OP_B: begin
        dec.br  = 1'b1;
        dec.alu = A_SUB;
        imm     = 3'b010;
        unique case (i_f3)
          3'b000: bad = 1'b0;
          3'b001, 3'b100, 3'b101,
          3'b110, 3'b111: bad = !EXT;
          default: bad = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.jal = 1'b1;
        dec.rw  = 1'b1;
        dec.opa = 1'b1;
        dec.opb = 1'b1;
        dec.rs  = 2'b10;
        imm     = 3'b011;
      end
      OP_JALR: begin
        dec.jalr = 1'b1;
        dec.rw   = 1'b1;
        dec.opb  = 1'b1;
        dec.rs   = 2'b10;
        bad      = (i_f3 != 3'b000);
      end
      OP_LUI: begin
        dec.rw = 1'b1;
        dec.rs = 2'b11;
        imm    = 3'b100;
      end
      OP_AUIPC: begin
        dec.rw  = 1'b1;
        dec.opa = 1'b1;
        dec.opb = 1'b1;
        imm     = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    dec.f3 = i_f3;
    // An undecodable word must not write, branch or jump anywhere.
    if (bad) begin
      dec     = '0;
      dec.ill = 1'b1;
      imm     = 3'b000;
    end
  end

  assign o_imm_src_d = imm;
  assign o_illegal_d = bad;

  always_comb begin
    unique case (ex_q.f3)
      3'b000:  taken = i_zero;
      3'b001:  taken = !i_zero;
      3'b100:  taken = i_lt;
      3'b101:  taken = !i_lt;
      3'b110:  taken = i_ltu;
      3'b111:  taken = !i_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    o_pc_src_e = 2'b00;
    unique case (1'b1)
      ex_q.jal:          o_pc_src_e = 2'b01;
      ex_q.jalr:         o_pc_src_e = 2'b10;
      ex_q.br && taken:  o_pc_src_e = 2'b01;
      default:           o_pc_src_e = 2'b00;
    endcase
  end

  assign o_flush_d = (o_pc_src_e != 2'b00);

  assign ex_d  = (i_flush_e | o_flush_d) ? '0 : dec;
  assign mem_d = '{rw: ex_q.rw, mw: ex_q.mw, rs: ex_q.rs};
  assign wb_d  = '{rw: mem_q.rw, rs: mem_q.rs};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign o_alu_ctl_e     = ALU_CTL_W'(ex_q.alu);
  assign o_alu_src_opa_e = ex_q.opa;
  assign o_alu_src_opb_e = ex_q.opb;
  assign o_load_e        = ex_q.load;
  assign o_illegal_e     = ex_q.ill;
  assign o_mem_write_m   = mem_q.mw;
  assign o_reg_write_m   = mem_q.rw;
  assign o_result_src_m  = mem_q.rs;
  assign o_reg_write_w   = wb_q.rw;
  assign o_result_src_w  = wb_q.rs;

endmodule

// File: tb/tb_pipelined_control_path.sv
// Scoreboard bench for pipelined_control_path: stage-tagged expectations
// are queued by the stimulus and retired by a negedge monitor.
module tb_pipelined_control_path;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] L   = 7'b0000011;
  localparam logic [6:0] S   = 7'b0100011;
  localparam logic [6:0] B   = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0] imm;
    logic       ill_d;
    logic [3:0] alu;
    logic       opa;
    logic       opb;
    logic [1:0] pc;
    logic       load;
    logic       ill_e;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
  } exp_t;

  typedef struct {
    int    cyc;
    int    stg;
    string nm;
    exp_t  e;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic f7, flush_e, zero, lt, ltu;

  logic [2:0] imm_d;
  logic ill_d, opa_e, opb_e, flush_d, load_e, ill_e;
  logic [3:0] alu_e;
  logic [1:0] pc_e, rs_m, rs_w;
  logic mw_m, rw_m, rw_w;

  logic [2:0] d2_imm_d;
  logic d2_ill_d, d2_opa_e, d2_opb_e, d2_flush_d, d2_load_e, d2_ill_e;
  logic [3:0] d2_alu_e;
  logic [1:0] d2_pc_e, d2_rs_m, d2_rs_w;
  logic d2_mw_m, d2_rw_m, d2_rw_w;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  item_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_control_path dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_f3(f3),
    .i_f7_b5(f7), .i_flush_e(flush_e), .i_zero(zero), .i_lt(lt),
    .i_ltu(ltu), .o_imm_src_d(imm_d), .o_illegal_d(ill_d),
    .o_alu_ctl_e(alu_e), .o_alu_src_opa_e(opa_e),
    .o_alu_src_opb_e(opb_e), .o_pc_src_e(pc_e), .o_flush_d(flush_d),
    .o_load_e(load_e), .o_illegal_e(ill_e), .o_mem_write_m(mw_m),
    .o_reg_write_m(rw_m), .o_result_src_m(rs_m),
    .o_reg_write_w(rw_w), .o_result_src_w(rs_w)
  );

  pipelined_control_path #(
    .ALU_CTL_W(4), .SUPPORT_SHIFTS(0), .SUPPORT_EXT_BRANCH(0)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_f3(f3),
    .i_f7_b5(f7), .i_flush_e(flush_e), .i_zero(zero), .i_lt(lt),
    .i_ltu(ltu), .o_imm_src_d(d2_imm_d), .o_illegal_d(d2_ill_d),
    .o_alu_ctl_e(d2_alu_e), .o_alu_src_opa_e(d2_opa_e),
    .o_alu_src_opb_e(d2_opb_e), .o_pc_src_e(d2_pc_e),
    .o_flush_d(d2_flush_d), .o_load_e(d2_load_e),
    .o_illegal_e(d2_ill_e), .o_mem_write_m(d2_mw_m),
    .o_reg_write_m(d2_rw_m), .o_result_src_m(d2_rs_m),
    .o_reg_write_w(d2_rw_w), .o_result_src_w(d2_rs_w)
  );

  function automatic exp_t mk(
    input logic [2:0] imm, input logic il_d, input logic [3:0] alu,
    input logic opa, input logic opb, input logic [1:0] pc,
    input logic load, input logic il_e, input logic mw,
    input logic rw, input logic [1:0] rs);
    exp_t e;
    e = '{imm: imm, ill_d: il_d, alu: alu, opa: opa, opb: opb,
          pc: pc, load: load, ill_e: il_e, mw: mw, rw: rw, rs: rs};
    return e;
  endfunction

  function automatic void push(input int c, input int s,
                               input string nm, input exp_t e);
    item_t it;
    it.cyc = c;
    it.stg = s;
    it.nm  = nm;
    it.e   = e;
    q.push_back(it);
  endfunction

  task automatic issue(input string nm, input logic [6:0] op,
                       input logic [2:0] fn3, input logic b5,
                       input logic fl, input logic z, input logic l,
                       input logic lu, input logic rn, input exp_t e);
    @(posedge clk);
    #2;
    rst_n = rn; opcode = op; f3 = fn3; f7 = b5;
    flush_e = fl; zero = z; lt = l; ltu = lu;
    push(cyc, 0, nm, e);
    push(cyc + 1, 1, nm, e);
    push(cyc + 2, 2, nm, e);
    push(cyc + 3, 3, nm, e);
  endtask

  task automatic chk2(input string nm, input logic il_d,
                      input logic [1:0] pc, input logic il_e);
    exp_t e;
    e = mk(3'd0, il_d, 4'd0, 1'b0, 1'b0, pc,
           1'b0, il_e, 1'b0, 1'b0, 2'd0);
    push(cyc, 4, nm, e);
    push(cyc + 1, 5, nm, e);
  endtask

  task automatic compare(input item_t it);
    logic [15:0] act, want;
    act  = '0;
    want = '0;
    case (it.stg)
      0: begin
        act  = 16'({imm_d, ill_d});
        want = 16'({it.e.imm, it.e.ill_d});
      end
      1: begin
        act  = 16'({alu_e, opa_e, opb_e, pc_e, flush_d, load_e, ill_e});
        want = 16'({it.e.alu, it.e.opa, it.e.opb, it.e.pc,
                    (it.e.pc != 2'b00), it.e.load, it.e.ill_e});
      end
      2: begin
        act  = 16'({mw_m, rw_m, rs_m});
        want = 16'({it.e.mw, it.e.rw, it.e.rs});
      end
      3: begin
        act  = 16'({rw_w, rs_w});
        want = 16'({it.e.rw, it.e.rs});
      end
      4: begin
        act  = 16'(d2_ill_d);
        want = 16'(it.e.ill_d);
      end
      default: begin
        act  = 16'({d2_pc_e, d2_ill_e});
        want = 16'({it.e.pc, it.e.ill_e});
      end
    endcase
    total++;
    if (act === want) passed++;
    else $display("FAIL %s stage%0d cyc%0d: got %h want %h",
                  it.nm, it.stg, it.cyc, act, want);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        compare(q[i]);
        q.delete(i);
      end
    end
  end

  initial begin
    exp_t z0;
    z0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; opcode = R; f3 = 3'b000; f7 = 1'b0;
    flush_e = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;

    issue("rst0", R, 3'b000, 0, 0, 0, 0, 0, 0, z0);
    issue("rst1", R, 3'b000, 0, 0, 0, 0, 0, 0, z0);
    issue("rst2", R, 3'b000, 0, 0, 0, 0, 0, 0, z0);
    issue("add", R, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("sub", R, 3'b000, 1, 0, 0, 0, 0, 1,
          mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("sll", R, 3'b001, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0));
    chk2("sll_noshift", 1, 2'b00, 1);
    issue("sra", R, 3'b101, 1, 0, 0, 0, 0, 1,
          mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("xori", I, 3'b100, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 4, 0, 1, 0, 0, 0, 0, 1, 0));
    issue("srai", I, 3'b101, 1, 0, 0, 0, 0, 1,
          mk(0, 0, 9, 0, 1, 0, 0, 0, 0, 1, 0));
    issue("bne", B, 3'b001, 0, 0, 0, 0, 0, 1,
          mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    issue("bne_kill", R, 3'b000, 0, 0, 0, 0, 0, 1, z0);
    issue("bgeu", B, 3'b111, 0, 0, 0, 0, 0, 1,
          mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    issue("add2", R, 3'b000, 0, 0, 0, 0, 1, 1,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    issue("blt", B, 3'b100, 0, 0, 0, 0, 0, 1,
          mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    issue("blt_kill", R, 3'b000, 0, 0, 0, 1, 0, 1, z0);
    issue("jalr", JR, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2));
    issue("jalr_kill", R, 3'b000, 0, 0, 0, 0, 0, 1, z0);
    issue("jal", JAL, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(3, 0, 0, 1, 1, 1, 0, 0, 0, 1, 2));
    issue("jal_kill", LUI, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue("lui", LUI, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3));
    issue("auipc", AUI, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(4, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    issue("lw", L, 3'b010, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    issue("loaduse", R, 3'b000, 0, 1, 0, 0, 0, 1, z0);
    issue("sw", S, 3'b010, 0, 0, 0, 0, 0, 1,
          mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    issue("illop", BAD, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk2("illop_d2", 1, 2'b00, 1);
    issue("beq", B, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk2("beq_d2", 0, 2'b00, 0);
    issue("bne2", B, 3'b001, 0, 0, 0, 0, 0, 1,
          mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    chk2("bne_noext", 1, 2'b00, 1);
    issue("bne2_kill", R, 3'b000, 0, 0, 0, 0, 0, 1, z0);
    issue("badf7", R, 3'b100, 1, 0, 0, 0, 0, 1,
          mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    issue("last", R, 3'b000, 0, 0, 0, 0, 0, 1,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    repeat (6) @(posedge clk);
    #2;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_control_path.md
Name: pipelined_control_path

Overview:
- Parametrised successor of the single-cycle control path for the RV32I core: decodes in ID and carries control through ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six branch conditions plus jal/jalr in EX and self-flushes the wrong-path instruction on a redirect.
- Adds shifts, lui/auipc and illegal-opcode detection.
- Sits between the instruction register (IF/ID) and the datapath; the hazard unit drives i_flush_e for load-use bubbles.

Parameters:
- ALU_CTL_W, 4: ALU control width; must be >=4; bits above [3] always 0.
- SUPPORT_SHIFTS, 1: 1 decodes sll/srl/sra/slli/srli/srai; 0 treats them as illegal.
- SUPPORT_EXT_BRANCH, 1: 1 decodes bne/blt/bge/bltu/bgeu; 0 leaves only beq legal among branches.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  synchronous active-low reset
- i_opcode  in  7  instr[6:0] from IF/ID
- i_f3  in  3  instr[14:12]
- i_f7_b5  in  1  instr[30]
- i_flush_e  in  1  hazard-unit bubble request into ID/EX
- i_zero  in  1  EX ALU result == 0
- i_lt  in  1  EX signed rs1<rs2
- i_ltu  in  1  EX unsigned rs1<rs2
- o_imm_src_d  out  3  comb. immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
- o_illegal_d  out  1  comb. opcode/funct undecodable
- o_alu_ctl_e  out  ALU_CTL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- o_alu_src_opa_e  out  1  1 = PC (auipc/jal), 0 = rs1
- o_alu_src_opb_e  out  1  1 = immediate
- o_pc_src_e  out  2  00 PC+4, 01 PC+imm, 10 ALU result (jalr)
- o_flush_d  out  1  redirect taken; kill IF/ID
- o_load_e  out  1  lw in EX (to hazard unit)
- o_illegal_e  out  1  registered illegal flag
- o_mem_write_m  out  1  store in MEM
- o_reg_write_m  out  1  for forwarding
- o_result_src_m  out  2  for forwarding
- o_reg_write_w  out  1  writeback enable
- o_result_src_w  out  2  00 ALU, 01 mem, 10 PC+4, 11 U-immediate

Behaviour:
- Interface (already decided): one clock, i_clk; reset is synchronous and active-low, i_rst_n.
- Reset: on an i_clk edge with i_rst_n=0, every ID/EX, EX/MEM and MEM/WB control field clears to 0, giving an all-zero bubble. All registered outputs read 0 the cycle after. Mid-operation reset discards in-flight control identically. o_pc_src_e=00 and o_flush_d=0 while EX holds a bubble.
- Decode (comb., ID):
  - R-type 0110011: f3/f7_b5 select the ALU op; reg_write=1.
  - lw 0000011: add, opb=1, result 01, reg_write.
  - I-ALU 0010011: f7_b5 is used only for srai (f3=101).
  - sw 0100011: S, mem_write.
  - branch 1100011: B, sub.
  - jal 1101111: J, result 10, reg_write.
  - jalr 1100111 (f3=000): I, add, opb=1, result 10.
  - lui 0110111: U, result 11.
  - auipc 0010111: U, opa=1, opb=1, add, result 00.
  - Any other encoding (including reserved f3 and disabled features) asserts o_illegal_d and forces all write enables/branch/jump to 0.
- Latency: ID decode appears on _e outputs 1 cycle later, _m after 2, _w after 3.
- ID/EX load: if i_flush_e | o_flush_d, load a bubble (illegal_e cleared too); else load decode. EX/MEM and MEM/WB always advance; there is no stall input.
- EX resolution (comb. from registered branch/jump/f3_e and flags):
  - beq: zero; bne: !zero; blt: lt; bge: !lt; bltu: ltu; bgeu: !ltu. Taken gives 01.
  - jal gives 01; jalr gives 10; otherwise 00.
  - o_flush_d = (o_pc_src_e != 00).
- Simultaneous events: reset > redirect self-flush = i_flush_e (both produce a bubble). A redirect and a load-use flush in the same cycle produce a single bubble.
- Back-to-back: a taken branch bubbles the next ID/EX, so two consecutive redirects cannot occur.

Test Plan:
- Reset: hold i_rst_n=0 with opcode 0110011 applied, then release -> all _e/_m/_w outputs are 0 until the first decode reaches them; o_reg_write_w=1 three edges after release.
- sub pipeline: opcode 0110011, f3=000, f7_b5=1 -> o_alu_ctl_e=0001 at +1, o_reg_write_m=1 at +2, o_result_src_w=00 at +3.
- Branches: bne with zero=0 -> pc_src=01, flush_d=1, next EX is a bubble; bgeu with ltu=1 -> pc_src=00; blt with lt=1 -> 01.
- jalr f3=000 -> pc_src_e=10, result_src_w=10. lui -> imm_src_d=100, result_src_w=11.
- Load-use: lw then i_flush_e=1 -> o_load_e=1, then a bubble in EX, and mem/reg writes of the bubble are 0.
- Illegal and features off: opcode 1111111 -> o_illegal_d=1, o_illegal_e=1 at +1, no writes. With SUPPORT_SHIFTS=0, sll -> illegal. With SUPPORT_EXT_BRANCH=0, bne -> illegal and pc_src=00.
